// File: rtl/trigger_latch_array_if.sv
// Trigger latch bank bus: trigger inputs and controls in, latched triggers, counts and overrun flags out.
interface trigger_latch_array_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned NSINK = 2,
    parameter int unsigned HW    = 8,
    parameter int unsigned CW    = 16
);
    logic [NCH-1:0]       trig;
    logic [NCH-1:0]       trig_en;
    logic [NCH-1:0]       trig_pol;
    logic [HW-1:0]        holdoff;
    logic [NSINK*NCH-1:0] clr;
    logic [NCH-1:0]       ovr_clr;
    logic [NSINK*NCH-1:0] trig_out;
    logic [NCH*CW-1:0]    trig_cnt;
    logic [NCH-1:0]       overrun;

    modport master (
        output trig, trig_en, trig_pol, holdoff, clr, ovr_clr,
        input  trig_out, trig_cnt, overrun
    );

    modport slave (
        input  trig, trig_en, trig_pol, holdoff, clr, ovr_clr,
        output trig_out, trig_cnt, overrun
    );
endinterface

// File: rtl/trigger_latch_array.sv
// Synchronised, edge-detected trigger bank latched into independently clearable per-sink
// outputs, with per-channel enable, retrigger holdoff, accepted-edge counter and overrun flag.
module trigger_latch_array #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned NSINK       = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HW          = 8,
    parameter int unsigned CW          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    trigger_latch_array_if.slave  bus
);
    localparam int unsigned NB    = NSINK * NCH;
    localparam int unsigned ARM_N = SYNC_STAGES + 1;
    localparam int unsigned AW    = $clog2(ARM_N + 1);

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_d [SYNC_STAGES];
    logic [NCH-1:0] prev_q, prev_d;
    logic [AW-1:0]  arm_q, arm_d;
    logic [HW-1:0]  hold_q [NCH];
    logic [HW-1:0]  hold_d [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NB-1:0]  out_q, out_d;
    logic [NCH-1:0] ovr_q, ovr_d;

    logic           armed_c;
    logic [NCH-1:0] sync_lvl_c;
    logic [NCH-1:0] edge_c;
    logic [NCH-1:0] acc_c;
    logic [NCH-1:0] busy_c;

    assign armed_c    = (arm_q == AW'(ARM_N));
    assign sync_lvl_c = sync_q[SYNC_STAGES-1];

    // Edge qualification: only compares synchronised level against its previous value,
    // so a polarity change alone never looks like an edge.
    always_comb begin
        edge_c = '0;
        acc_c  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            edge_c[c] = bus.trig_pol[c] ? (~sync_lvl_c[c] & prev_q[c])
                                        : (sync_lvl_c[c] & ~prev_q[c]);
            acc_c[c]  = armed_c & edge_c[c] & bus.trig_en[c] & (hold_q[c] == '0);
        end
    end

    always_comb begin
        sync_d[0] = bus.trig;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_lvl_c;
        arm_d  = armed_c ? arm_q : arm_q + AW'(1);
    end

    always_comb begin
        out_d  = out_q;
        ovr_d  = ovr_q;
        busy_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            hold_d[c] = hold_q[c];
            cnt_d[c]  = cnt_q[c];
            if (acc_c[c]) begin
                hold_d[c] = bus.holdoff;
                cnt_d[c]  = cnt_q[c] + CW'(1);
            end else if (hold_q[c] != '0) begin
                hold_d[c] = hold_q[c] - HW'(1);
            end
            // A sink still holding an uncleared trigger makes the new accept an overrun.
            for (int unsigned s = 0; s < NSINK; s++) begin
                busy_c[c] = busy_c[c] | (out_q[s*NCH+c] & ~bus.clr[s*NCH+c]);
                if (bus.clr[s*NCH+c]) begin
                    out_d[s*NCH+c] = 1'b0;
                end else if (acc_c[c]) begin
                    out_d[s*NCH+c] = 1'b1;
                end
            end
            if (acc_c[c] && busy_c[c]) begin
                ovr_d[c] = 1'b1;
            end else if (bus.ovr_clr[c]) begin
                ovr_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                hold_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            prev_q <= '0;
            arm_q  <= '0;
            out_q  <= '0;
            ovr_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                hold_q[c] <= hold_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            prev_q <= prev_d;
            arm_q  <= arm_d;
            out_q  <= out_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.trig_out = out_q;
    assign bus.overrun  = ovr_q;

    always_comb begin
        bus.trig_cnt = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            bus.trig_cnt[c*CW +: CW] = cnt_q[c];
        end
    end
endmodule

// File: tb/tb_trigger_latch_array.sv
// Self-checking bench for trigger_latch_array: directed vector table, hand-written corner
// sequences and randomised traffic checked every cycle against a history-based reference model.
module tb_trigger_latch_array;
    localparam int unsigned NCH   = 4;
    localparam int unsigned NSINK = 2;
    localparam int unsigned SS    = 2;
    localparam int unsigned HW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned NB    = NSINK * NCH;

    logic clk;
    logic rst_n;

    trigger_latch_array_if #(.NCH(NCH), .NSINK(NSINK), .HW(HW), .CW(CW)) bus ();

    trigger_latch_array #(
        .NCH(NCH), .NSINK(NSINK), .SYNC_STAGES(SS), .HW(HW), .CW(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: trigger level seen by edge detection is the input sampled SS edges
    // earlier; detection is allowed from the (SS+2)th clock edge after reset release.
    int             m_n;
    logic [NCH-1:0] hist[$];
    logic [NB-1:0]  m_out;
    logic [NCH-1:0] m_ovr;
    int             m_cnt  [NCH];
    int             m_hold [NCH];

    task automatic m_reset();
        m_n = 0;
        hist.delete();
        for (int i = 0; i <= int'(SS); i++) hist.push_back('0);
        m_out = '0;
        m_ovr = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            m_cnt[c]  = 0;
            m_hold[c] = 0;
        end
    endtask

    task automatic m_step();
        logic [NCH-1:0] lvl, prv;
        logic [NB-1:0]  nout;
        bit edge_seen, acc, busy;
        m_n++;
        lvl  = hist[SS-1];
        prv  = hist[SS];
        nout = m_out;
        for (int c = 0; c < int'(NCH); c++) begin
            edge_seen = bus.trig_pol[c] ? (!lvl[c] && prv[c]) : (lvl[c] && !prv[c]);
            acc = (m_n >= int'(SS) + 2) && edge_seen && bus.trig_en[c] && (m_hold[c] == 0);
            busy = 0;
            for (int s = 0; s < int'(NSINK); s++) begin
                if (m_out[s*NCH+c] && !bus.clr[s*NCH+c]) busy = 1;
                if (bus.clr[s*NCH+c]) nout[s*NCH+c] = 1'b0;
                else if (acc)         nout[s*NCH+c] = 1'b1;
            end
            if (acc && busy)          m_ovr[c] = 1'b1;
            else if (bus.ovr_clr[c])  m_ovr[c] = 1'b0;
            if (acc) begin
                m_cnt[c]  = (m_cnt[c] + 1) % (1 << CW);
                m_hold[c] = int'(bus.holdoff);
            end else if (m_hold[c] > 0) begin
                m_hold[c] = m_hold[c] - 1;
            end
        end
        m_out = nout;
        hist.push_front(bus.trig);
        void'(hist.pop_back());
    endtask

    function automatic logic [NCH*CW-1:0] m_cnt_vec();
        logic [NCH*CW-1:0] v;
        v = '0;
        for (int c = 0; c < int'(NCH); c++) v[c*CW +: CW] = CW'(m_cnt[c]);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // One clock: model advances on the rising edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
        chk("model_out", 64'(bus.trig_out), 64'(m_out));
        chk("model_cnt", 64'(bus.trig_cnt), 64'(m_cnt_vec()));
        chk("model_ovr", 64'(bus.overrun),  64'(m_ovr));
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return bus.trig_cnt[ch*CW +: CW];
    endfunction

    typedef struct {
        logic [NCH-1:0] trig;
        logic [NB-1:0]  clr;
        logic [NB-1:0]  exp_out;
        int             ch;
        int             exp_cnt;
        logic [NCH-1:0] exp_ovr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{4'b0011, 8'h00, 8'h00, 1, 0, 4'b0000};
        tbl[1] = '{4'b0011, 8'h00, 8'h00, 1, 0, 4'b0000};
        tbl[2] = '{4'b0011, 8'h00, 8'h22, 1, 1, 4'b0000};
        tbl[3] = '{4'b0011, 8'h02, 8'h20, 1, 1, 4'b0000};
        tbl[4] = '{4'b0011, 8'h00, 8'h20, 1, 1, 4'b0000};
        tbl[5] = '{4'b0111, 8'h00, 8'h20, 2, 0, 4'b0000};
        tbl[6] = '{4'b0111, 8'h00, 8'h20, 2, 0, 4'b0000};
        tbl[7] = '{4'b0111, 8'h04, 8'h60, 2, 1, 4'b0000};
        tbl[8] = '{4'b0111, 8'h00, 8'h60, 2, 1, 4'b0000};

        rst_n        = 1'b0;
        bus.trig     = 4'b0001;
        bus.trig_en  = '1;
        bus.trig_pol = '0;
        bus.holdoff  = '0;
        bus.clr      = '0;
        bus.ovr_clr  = '0;
        m_reset();

        // Trigger held high through reset release must not fire.
        repeat (3) @(negedge clk);
        chk("rst_out", 64'(bus.trig_out), 64'h0);
        chk("rst_cnt", 64'(bus.trig_cnt), 64'h0);
        chk("rst_ovr", 64'(bus.overrun),  64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("arm_out",  64'(bus.trig_out), 64'h0);
            chk("arm_cnt0", 64'(cnt_of(0)),    64'h0);
        end

        // Latency, per-sink clear, and clear beating a same-cycle set.
        foreach (tbl[i]) begin
            bus.trig = tbl[i].trig;
            bus.clr  = tbl[i].clr;
            step();
            chk("vec_out", 64'(bus.trig_out),     64'(tbl[i].exp_out));
            chk("vec_cnt", 64'(cnt_of(tbl[i].ch)), 64'(tbl[i].exp_cnt));
            chk("vec_ovr", 64'(bus.overrun),      64'(tbl[i].exp_ovr));
        end
        bus.clr = '0;

        // Holdoff: pulses at relative cycles 0, 3, 8 with HOLDOFF=5.
        bus.trig[0] = 1'b0;
        repeat (4) step();
        bus.holdoff = HW'(5);
        for (int i = 0; i < 13; i++) begin
            bus.trig[0] = (i == 0 || i == 3 || i == 8);
            step();
        end
        repeat (3) step();
        chk("hold_cnt0", 64'(cnt_of(0)),          64'd2);
        chk("hold_ovr0", 64'(bus.overrun[0]),     64'd1);
        chk("hold_out0", 64'(bus.trig_out & 8'h11), 64'h11);
        bus.holdoff = '0;
        bus.ovr_clr = 4'b0001;
        step();
        bus.ovr_clr = '0;
        chk("ovrclr", 64'(bus.overrun[0]), 64'd0);

        // Falling-edge polarity on channel 3.
        bus.trig_pol[3] = 1'b1;
        bus.trig[3]     = 1'b1;
        repeat (5) step();
        chk("pol_rise", 64'(bus.trig_out & 8'h88), 64'h0);
        bus.trig[3] = 1'b0;
        repeat (2) step();
        chk("pol_early", 64'(bus.trig_out & 8'h88), 64'h0);
        step();
        chk("pol_fall", 64'(bus.trig_out & 8'h88), 64'h88);
        chk("pol_cnt3", 64'(cnt_of(3)),            64'd1);
        bus.clr = 8'h88;
        step();
        bus.clr = '0;
        for (int i = 0; i < 6; i++) begin
            bus.trig_pol[3] = ~bus.trig_pol[3];
            step();
        end
        repeat (4) step();
        chk("pol_toggle", 64'(bus.trig_out & 8'h88), 64'h0);
        chk("pol_cnt3b",  64'(cnt_of(3)),            64'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if ($urandom_range(0, 3) == 0)  bus.trig[c]     = ~bus.trig[c];
                if ($urandom_range(0, 15) == 0) bus.trig_pol[c] = ~bus.trig_pol[c];
                bus.trig_en[c] = ($urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 15) == 0) bus.holdoff = HW'($urandom_range(0, 6));
            bus.clr     = NB'($urandom & $urandom & $urandom);
            bus.ovr_clr = NCH'($urandom & $urandom & $urandom);
            step();
        end

        // Counter wrap after a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        bus.trig = '0; bus.trig_en = '1; bus.trig_pol = '0;
        bus.holdoff = '0; bus.clr = '0; bus.ovr_clr = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 15; k++) begin
            bus.trig[0] = 1'b1; step();
            bus.trig[0] = 1'b0; step();
        end
        repeat (3) step();
        chk("wrap_15", 64'(cnt_of(0)), 64'd15);
        bus.trig[0] = 1'b1; step();
        bus.trig[0] = 1'b0; step();
        repeat (3) step();
        chk("wrap_0", 64'(cnt_of(0)), 64'd0);

        // Asynchronous reset in the middle of a long holdoff.
        bus.holdoff = HW'(20);
        bus.trig[1] = 1'b1;
        repeat (3) step();
        chk("ho_set", 64'(bus.trig_out & 8'h22), 64'h22);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", 64'(bus.trig_out), 64'h0);
        chk("async_cnt", 64'(bus.trig_cnt), 64'h0);
        chk("async_ovr", 64'(bus.overrun),  64'h0);
        m_reset();
        bus.trig = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        bus.trig[1] = 1'b1;
        repeat (3) step();
        chk("post_rst", 64'(bus.trig_out), 64'h22);
        chk("post_cnt", 64'(cnt_of(1)),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
